// File: rtl/ip_msx50bus_pkg.sv
// Shared state encoding and constants for the MSX50 cartridge-bus bridge.
package ip_msx50bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_DRIVE,
    RD_IGNORE,
    WR_ACTIVE
  } state_t;

  localparam logic [7:0] IDLE_DATA  = 8'hFF;
  localparam int         SYNC_DEPTH = 2;

endpackage

// File: rtl/ip_msx50bus_bridge_if.sv
// Internal peripheral-side bus of the MSX50 bridge; the bridge is the master.
interface ip_msx50bus_bridge_if;

  logic [15:0] bus_address;
  logic        bus_memory_read;
  logic        bus_memory_write;
  logic [7:0]  bus_write_data;
  logic        bus_read_ready;
  logic [7:0]  bus_read_data;

  modport master (
    output bus_address, bus_memory_read, bus_memory_write, bus_write_data,
    input  bus_read_ready, bus_read_data
  );

  modport slave (
    input  bus_address, bus_memory_read, bus_memory_write, bus_write_data,
    output bus_read_ready, bus_read_data
  );

endinterface

// File: rtl/ip_msx50bus_sync.sv
// Multi-flop synchronizer for one asynchronous active-low strobe; resets to the inactive level.
module ip_msx50bus_sync
  import ip_msx50bus_pkg::*;
(
  input  logic clk,
  input  logic n_reset,
  input  logic d,
  output logic q
);

  logic [SYNC_DEPTH-1:0] ff;

  always_ff @(posedge clk) begin
    if (!n_reset) ff <= '1;
    else          ff <= {ff[SYNC_DEPTH-2:0], d};
  end

  assign q = ff[SYNC_DEPTH-1];

endmodule

// File: rtl/ip_msx50bus_bridge.sv
// MSX50 cartridge slot to internal memory bus bridge with read timeout.
// Optional Z80 wait generation during reads is enabled by defining IP_MSX50BUS_WAIT_EN.
module ip_msx50bus_bridge
  import ip_msx50bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        msx_n_sltsl,
  input  logic        msx_n_rd,
  input  logic        msx_n_wr,
  input  logic [15:0] msx_a,
  input  logic [7:0]  msx_d_in,
  output logic [7:0]  msx_d_out,
  output logic        msx_d_oe,
`ifdef IP_MSX50BUS_WAIT_EN
  output logic        msx_n_wait,
`endif
  ip_msx50bus_bridge_if.master bus_if
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  logic sltsl_s, rd_s, wr_s;

  ip_msx50bus_sync u_sync_sltsl (.clk(clk), .n_reset(n_reset), .d(msx_n_sltsl), .q(sltsl_s));
  ip_msx50bus_sync u_sync_rd    (.clk(clk), .n_reset(n_reset), .d(msx_n_rd),    .q(rd_s));
  ip_msx50bus_sync u_sync_wr    (.clk(clk), .n_reset(n_reset), .d(msx_n_wr),    .q(wr_s));

  state_t           state, state_nxt;
  logic             rd_q, rd_nxt, wr_q, wr_nxt, oe_q, oe_nxt;
  logic [15:0]      addr_q, addr_nxt;
  logic [7:0]       wdata_q, wdata_nxt, dout_q, dout_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state   <= IDLE;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      oe_q    <= 1'b0;
      addr_q  <= 16'h0000;
      wdata_q <= 8'h00;
      dout_q  <= IDLE_DATA;
      cnt_q   <= '0;
    end else begin
      state   <= state_nxt;
      rd_q    <= rd_nxt;
      wr_q    <= wr_nxt;
      oe_q    <= oe_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
      dout_q  <= dout_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rd_nxt    = rd_q;
    wr_nxt    = wr_q;
    oe_nxt    = oe_q;
    addr_nxt  = addr_q;
    wdata_nxt = wdata_q;
    dout_nxt  = dout_q;
    cnt_nxt   = cnt_q;
    case (state)
      IDLE: begin
        // Simultaneous rd and wr is a bus glitch and matches neither branch.
        if (!sltsl_s && !rd_s && wr_s) begin
          addr_nxt  = msx_a;
          rd_nxt    = 1'b1;
          cnt_nxt   = '0;
          state_nxt = RD_WAIT;
        end else if (!sltsl_s && !wr_s && rd_s) begin
          addr_nxt  = msx_a;
          wdata_nxt = msx_d_in;
          wr_nxt    = 1'b1;
          state_nxt = WR_ACTIVE;
        end
      end
      RD_WAIT: begin
        if (rd_s || sltsl_s) begin
          rd_nxt    = 1'b0;
          state_nxt = IDLE;
        end else if (bus_if.bus_read_ready) begin
          dout_nxt  = bus_if.bus_read_data;
          rd_nxt    = 1'b0;
          oe_nxt    = 1'b1;
          state_nxt = RD_DRIVE;
        end else if (cnt_q >= CNT_LAST) begin
          rd_nxt    = 1'b0;
          state_nxt = RD_IGNORE;
        end else begin
          cnt_nxt = sat_inc(cnt_q);
        end
      end
      RD_DRIVE, RD_IGNORE: begin
        if (rd_s || sltsl_s) begin
          oe_nxt    = 1'b0;
          dout_nxt  = IDLE_DATA;
          state_nxt = IDLE;
        end
      end
      WR_ACTIVE: begin
        if (wr_s || sltsl_s) begin
          wr_nxt    = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus_if.bus_address      = addr_q;
  assign bus_if.bus_memory_read  = rd_q;
  assign bus_if.bus_memory_write = wr_q;
  assign bus_if.bus_write_data   = wdata_q;
  assign msx_d_out               = dout_q;
  assign msx_d_oe                = oe_q;

`ifdef IP_MSX50BUS_WAIT_EN
  assign msx_n_wait = (state != RD_WAIT);
`endif

endmodule

// File: tb/tb_ip_msx50bus_bridge.sv
// Directed bench for ip_msx50bus_bridge: write, read, timeout, rd+wr glitch and reset-in-read scenarios.
module tb_ip_msx50bus_bridge;
  import ip_msx50bus_pkg::*;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        msx_n_sltsl, msx_n_rd, msx_n_wr;
  logic [15:0] msx_a;
  logic [7:0]  msx_d_in;
  logic [7:0]  msx_d_out;
  logic        msx_d_oe;
`ifdef IP_MSX50BUS_WAIT_EN
  logic        msx_n_wait;
`endif
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ip_msx50bus_bridge_if bus_if ();

  ip_msx50bus_bridge #(.TIMEOUT_CYCLES(16)) dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .msx_n_sltsl (msx_n_sltsl),
    .msx_n_rd    (msx_n_rd),
    .msx_n_wr    (msx_n_wr),
    .msx_a       (msx_a),
    .msx_d_in    (msx_d_in),
    .msx_d_out   (msx_d_out),
    .msx_d_oe    (msx_d_oe),
`ifdef IP_MSX50BUS_WAIT_EN
    .msx_n_wait  (msx_n_wait),
`endif
    .bus_if      (bus_if.master)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_release();
    msx_n_sltsl = 1'b1;
    msx_n_rd    = 1'b1;
    msx_n_wr    = 1'b1;
  endtask

  task automatic test_reset();
    bus_release();
    msx_a = 16'h0000; msx_d_in = 8'h00;
    bus_if.bus_read_ready = 1'b0; bus_if.bus_read_data = 8'h00;
    n_reset = 1'b0;
    tick(2);
    n_cmp++; if (bus_if.bus_memory_read !== 1'b0) begin n_bad++; $display("FAIL rst_read got %b want 0", bus_if.bus_memory_read); end
    n_cmp++; if (bus_if.bus_memory_write !== 1'b0) begin n_bad++; $display("FAIL rst_write got %b want 0", bus_if.bus_memory_write); end
    n_cmp++; if (bus_if.bus_address !== 16'h0000) begin n_bad++; $display("FAIL rst_addr got %h want 0000", bus_if.bus_address); end
    n_cmp++; if (bus_if.bus_write_data !== 8'h00) begin n_bad++; $display("FAIL rst_wdata got %h want 00", bus_if.bus_write_data); end
    n_cmp++; if (msx_d_out !== 8'hFF) begin n_bad++; $display("FAIL rst_dout got %h want ff", msx_d_out); end
    n_cmp++; if (msx_d_oe !== 1'b0) begin n_bad++; $display("FAIL rst_oe got %b want 0", msx_d_oe); end
`ifdef IP_MSX50BUS_WAIT_EN
    n_cmp++; if (msx_n_wait !== 1'b1) begin n_bad++; $display("FAIL rst_wait got %b want 1", msx_n_wait); end
`endif
    n_reset = 1'b1;
    tick(3);
    n_cmp++; if (dut.state !== IDLE) begin n_bad++; $display("FAIL rst_state got %0d want %0d", dut.state, IDLE); end
  endtask

  task automatic test_write();
    msx_a = 16'h9000; msx_d_in = 8'h5A;
    msx_n_sltsl = 1'b0; msx_n_wr = 1'b0;
    tick(2);
    n_cmp++; if (bus_if.bus_memory_write !== 1'b0) begin n_bad++; $display("FAIL wr_early got %b want 0", bus_if.bus_memory_write); end
    tick(1);
    n_cmp++; if (bus_if.bus_memory_write !== 1'b1) begin n_bad++; $display("FAIL wr_assert got %b want 1", bus_if.bus_memory_write); end
    n_cmp++; if (bus_if.bus_address !== 16'h9000) begin n_bad++; $display("FAIL wr_addr got %h want 9000", bus_if.bus_address); end
    n_cmp++; if (bus_if.bus_write_data !== 8'h5A) begin n_bad++; $display("FAIL wr_data got %h want 5a", bus_if.bus_write_data); end
    msx_d_in = 8'h00; msx_a = 16'hFFFF;
    tick(4);
    n_cmp++; if (bus_if.bus_memory_write !== 1'b1) begin n_bad++; $display("FAIL wr_hold got %b want 1", bus_if.bus_memory_write); end
    n_cmp++; if (bus_if.bus_write_data !== 8'h5A) begin n_bad++; $display("FAIL wr_data_hold got %h want 5a", bus_if.bus_write_data); end
    msx_n_wr = 1'b1;
    tick(2);
    n_cmp++; if (bus_if.bus_memory_write !== 1'b1) begin n_bad++; $display("FAIL wr_drop_early got %b want 1", bus_if.bus_memory_write); end
    tick(1);
    n_cmp++; if (bus_if.bus_memory_write !== 1'b0) begin n_bad++; $display("FAIL wr_drop got %b want 0", bus_if.bus_memory_write); end
    n_cmp++; if (bus_if.bus_address !== 16'h9000) begin n_bad++; $display("FAIL wr_addr_stable got %h want 9000", bus_if.bus_address); end
    bus_release();
    tick(3);
  endtask

  task automatic test_read();
    msx_a = 16'h9000;
    msx_n_sltsl = 1'b0; msx_n_rd = 1'b0;
    tick(2);
    n_cmp++; if (bus_if.bus_memory_read !== 1'b0) begin n_bad++; $display("FAIL rd_early got %b want 0", bus_if.bus_memory_read); end
`ifdef IP_MSX50BUS_WAIT_EN
    n_cmp++; if (msx_n_wait !== 1'b1) begin n_bad++; $display("FAIL wait_before got %b want 1", msx_n_wait); end
`endif
    tick(1);
    n_cmp++; if (bus_if.bus_memory_read !== 1'b1) begin n_bad++; $display("FAIL rd_assert got %b want 1", bus_if.bus_memory_read); end
    n_cmp++; if (bus_if.bus_address !== 16'h9000) begin n_bad++; $display("FAIL rd_addr got %h want 9000", bus_if.bus_address); end
`ifdef IP_MSX50BUS_WAIT_EN
    n_cmp++; if (msx_n_wait !== 1'b0) begin n_bad++; $display("FAIL wait_during got %b want 0", msx_n_wait); end
`endif
    tick(4);
    n_cmp++; if (msx_d_oe !== 1'b0) begin n_bad++; $display("FAIL rd_oe_wait got %b want 0", msx_d_oe); end
    bus_if.bus_read_ready = 1'b1; bus_if.bus_read_data = 8'hA5;
    tick(1);
    bus_if.bus_read_ready = 1'b0; bus_if.bus_read_data = 8'h00;
    n_cmp++; if (msx_d_oe !== 1'b1) begin n_bad++; $display("FAIL rd_oe got %b want 1", msx_d_oe); end
    n_cmp++; if (msx_d_out !== 8'hA5) begin n_bad++; $display("FAIL rd_dout got %h want a5", msx_d_out); end
    n_cmp++; if (bus_if.bus_memory_read !== 1'b0) begin n_bad++; $display("FAIL rd_deassert got %b want 0", bus_if.bus_memory_read); end
`ifdef IP_MSX50BUS_WAIT_EN
    n_cmp++; if (msx_n_wait !== 1'b1) begin n_bad++; $display("FAIL wait_after got %b want 1", msx_n_wait); end
`endif
    tick(3);
    n_cmp++; if (msx_d_out !== 8'hA5 || msx_d_oe !== 1'b1) begin n_bad++; $display("FAIL rd_hold got oe=%b d=%h want oe=1 d=a5", msx_d_oe, msx_d_out); end
    msx_n_rd = 1'b1;
    tick(2);
    n_cmp++; if (msx_d_oe !== 1'b1) begin n_bad++; $display("FAIL rd_oe_late got %b want 1", msx_d_oe); end
    tick(1);
    n_cmp++; if (msx_d_oe !== 1'b0) begin n_bad++; $display("FAIL rd_oe_off got %b want 0", msx_d_oe); end
    n_cmp++; if (msx_d_out !== 8'hFF) begin n_bad++; $display("FAIL rd_dout_idle got %h want ff", msx_d_out); end
    bus_release();
    tick(3);
  endtask

  task automatic test_timeout();
    msx_a = 16'hA000;
    msx_n_sltsl = 1'b0; msx_n_rd = 1'b0;
    tick(3);
    n_cmp++; if (bus_if.bus_memory_read !== 1'b1) begin n_bad++; $display("FAIL to_assert got %b want 1", bus_if.bus_memory_read); end
    tick(15);
    n_cmp++; if (bus_if.bus_memory_read !== 1'b1) begin n_bad++; $display("FAIL to_early got %b want 1", bus_if.bus_memory_read); end
    tick(1);
    n_cmp++; if (bus_if.bus_memory_read !== 1'b0) begin n_bad++; $display("FAIL to_drop got %b want 0", bus_if.bus_memory_read); end
    n_cmp++; if (dut.state !== RD_IGNORE) begin n_bad++; $display("FAIL to_state got %0d want %0d", dut.state, RD_IGNORE); end
`ifdef IP_MSX50BUS_WAIT_EN
    n_cmp++; if (msx_n_wait !== 1'b1) begin n_bad++; $display("FAIL to_wait got %b want 1", msx_n_wait); end
`endif
    tick(3);
    n_cmp++; if (msx_d_oe !== 1'b0) begin n_bad++; $display("FAIL to_oe got %b want 0", msx_d_oe); end
    bus_release();
    tick(3);
    n_cmp++; if (dut.state !== IDLE) begin n_bad++; $display("FAIL to_idle got %0d want %0d", dut.state, IDLE); end
    msx_a = 16'h1234; msx_d_in = 8'h33;
    msx_n_sltsl = 1'b0; msx_n_wr = 1'b0;
    tick(3);
    n_cmp++; if (bus_if.bus_memory_write !== 1'b1) begin n_bad++; $display("FAIL to_next_wr got %b want 1", bus_if.bus_memory_write); end
    n_cmp++; if (bus_if.bus_address !== 16'h1234) begin n_bad++; $display("FAIL to_next_addr got %h want 1234", bus_if.bus_address); end
    bus_release();
    tick(3);
    n_cmp++; if (bus_if.bus_memory_write !== 1'b0) begin n_bad++; $display("FAIL to_next_drop got %b want 0", bus_if.bus_memory_write); end
  endtask

  task automatic test_both_low();
    msx_a = 16'h4000; msx_d_in = 8'h77;
    msx_n_sltsl = 1'b0; msx_n_rd = 1'b0; msx_n_wr = 1'b0;
    tick(6);
    n_cmp++; if (bus_if.bus_memory_read !== 1'b0) begin n_bad++; $display("FAIL both_read got %b want 0", bus_if.bus_memory_read); end
    n_cmp++; if (bus_if.bus_memory_write !== 1'b0) begin n_bad++; $display("FAIL both_write got %b want 0", bus_if.bus_memory_write); end
    n_cmp++; if (bus_if.bus_address !== 16'h1234) begin n_bad++; $display("FAIL both_addr got %h want 1234", bus_if.bus_address); end
    bus_release();
    tick(3);
  endtask

  task automatic test_reset_in_drive();
    msx_a = 16'h8000;
    msx_n_sltsl = 1'b0; msx_n_rd = 1'b0;
    tick(3);
    bus_if.bus_read_ready = 1'b1; bus_if.bus_read_data = 8'h3C;
    tick(1);
    bus_if.bus_read_ready = 1'b0;
    n_cmp++; if (msx_d_oe !== 1'b1 || msx_d_out !== 8'h3C) begin n_bad++; $display("FAIL rdr_drive got oe=%b d=%h want oe=1 d=3c", msx_d_oe, msx_d_out); end
    n_reset = 1'b0;
    tick(1);
    n_cmp++; if (msx_d_oe !== 1'b0) begin n_bad++; $display("FAIL rdr_oe got %b want 0", msx_d_oe); end
    n_cmp++; if (msx_d_out !== 8'hFF) begin n_bad++; $display("FAIL rdr_dout got %h want ff", msx_d_out); end
    n_cmp++; if (dut.state !== IDLE) begin n_bad++; $display("FAIL rdr_state got %0d want %0d", dut.state, IDLE); end
    n_cmp++; if (bus_if.bus_address !== 16'h0000) begin n_bad++; $display("FAIL rdr_addr got %h want 0000", bus_if.bus_address); end
    bus_release();
    n_reset = 1'b1;
    tick(3);
    n_cmp++; if (dut.state !== IDLE || msx_d_oe !== 1'b0) begin n_bad++; $display("FAIL rdr_after got st=%0d oe=%b want st=%0d oe=0", dut.state, msx_d_oe, IDLE); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_both_low();
    test_reset_in_drive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
